// File: rtl/ras_ctrl_if.sv
// ----------------------------------------------------------------------------
// ras_ctrl_if
// Hint handshake between the IF-stage predecoder (master) and the RAS
// sequencer (slave), together with the same-cycle return-target prediction.
//   req_valid   master -> slave  predecoder presents a hint
//   req_ready   slave  -> master hint accepted this cycle
//   req_kind    master -> slave  0 NONE, 1 CALL, 2 RET, 3 CALL_RET
//   req_pc      master -> slave  PC of the call/return instruction
//   pred_valid  slave  -> master pred_target usable in the accept cycle
//   pred_target slave  -> master predicted return target
// ----------------------------------------------------------------------------
interface ras_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_kind;
   logic [31:0] req_pc;
   logic        pred_valid;
   logic [31:0] pred_target;

   modport master (
      output req_valid, req_kind, req_pc,
      input  req_ready, pred_valid, pred_target
   );

   modport slave (
      input  req_valid, req_kind, req_pc,
      output req_ready, pred_valid, pred_target
   );
endinterface

// File: rtl/ras_ctrl.sv
// ----------------------------------------------------------------------------
// ras_ctrl
// Sequencer between the predecoder and the return address stack. One hint is
// accepted per cycle; the resulting push/pop is registered into the RAS one
// cycle later. A same-cycle prediction bypasses a push still in flight.
// Tracks stack depth, sequences flushes and counts commit-time hits/misses.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   flush_in          backend flush (mispredict/exception)
//   req_if            hint handshake + prediction (slave side)
//   ras_push_req/ras_pop_req/ras_push_data/ras_flush   commands to the RAS
//   ras_top_valid/ras_top_data                         RAS top entry
//   commit_ret_valid/commit_ret_hit                    retired return outcome
//   hit_cnt/miss_cnt  saturating statistics counters
// ----------------------------------------------------------------------------
module ras_ctrl #(
   parameter int ENTRIES_NUM = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_in,
   ras_ctrl_if.slave        req_if,
   output logic             ras_push_req,
   output logic             ras_pop_req,
   output logic [31:0]      ras_push_data,
   output logic             ras_flush,
   input  logic             ras_top_valid,
   input  logic [31:0]      ras_top_data,
   input  logic             commit_ret_valid,
   input  logic             commit_ret_hit,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);
   localparam int DEPTH_W = $clog2(ENTRIES_NUM + 1);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(ENTRIES_NUM);

   localparam logic [1:0] KIND_NONE     = 2'd0;
   localparam logic [1:0] KIND_CALL     = 2'd1;
   localparam logic [1:0] KIND_RET      = 2'd2;
   localparam logic [1:0] KIND_CALL_RET = 2'd3;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_next;

   // Stage register S: hint accepted last cycle, driving the RAS this cycle
   logic               r_s_valid;
   logic [1:0]         r_s_kind;
   logic [31:0]        r_s_addr;

   logic [DEPTH_W-1:0] r_depth;
   logic [DEPTH_W-1:0] w_depth_next;
   logic [CNT_W-1:0]   r_hit_cnt;
   logic [CNT_W-1:0]   r_miss_cnt;

   logic               w_ready;
   logic               w_ras_flush;
   logic               w_accept;
   logic               w_s_push;
   logic               w_req_is_ret;
   logic               w_depth_nz;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      w_ras_flush  = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_ready = !flush_in;
            if (flush_in) begin
               w_state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            w_ras_flush = 1'b1;
            // A flush arriving while flushing extends the flush by a cycle
            if (!flush_in) begin
               w_state_next = ST_RUN;
            end
         end
         default: w_state_next = ST_RUN;
      endcase
   end

   assign w_accept     = req_if.req_valid && w_ready;
   assign w_depth_nz   = (r_depth != '0);
   assign w_s_push     = r_s_valid && ((r_s_kind == KIND_CALL) || (r_s_kind == KIND_CALL_RET));
   assign w_req_is_ret = (req_if.req_kind == KIND_RET) || (req_if.req_kind == KIND_CALL_RET);

   // ---------------------------------------------------------------- stage S
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s_valid <= 1'b0;
         r_s_kind  <= KIND_NONE;
         r_s_addr  <= '0;
      end else if (w_accept) begin
         r_s_valid <= (req_if.req_kind != KIND_NONE);
         r_s_kind  <= req_if.req_kind;
         r_s_addr  <= req_if.req_pc + 32'd8;   // skip delay slot, wraps mod 2^32
      end else begin
         r_s_valid <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- depth
   // CALL_RET is a replace-top in the RAS, so depth only moves when the
   // stack was empty (the replace then behaves as a plain push).
   always_comb begin
      w_depth_next = r_depth;
      if (flush_in) begin
         w_depth_next = '0;
      end else if (r_s_valid) begin
         case (r_s_kind)
            KIND_CALL: begin
               if (r_depth != DEPTH_MAX) begin
                  w_depth_next = r_depth + 1'b1;
               end
            end
            KIND_RET: begin
               if (w_depth_nz) begin
                  w_depth_next = r_depth - 1'b1;
               end
            end
            KIND_CALL_RET: begin
               if (!w_depth_nz) begin
                  w_depth_next = DEPTH_W'(1);
               end
            end
            default: w_depth_next = r_depth;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_depth <= '0;
      end else begin
         r_depth <= w_depth_next;
      end
   end

   // ---------------------------------------------------------------- RAS cmds
   assign ras_push_req  = w_s_push;
   assign ras_pop_req   = r_s_valid && (r_s_kind == KIND_RET) && w_depth_nz;
   assign ras_push_data = r_s_addr;
   assign ras_flush     = w_ras_flush;

   // ---------------------------------------------------------------- prediction
   // A push in S is not yet in the RAS, so forward its address. A pop in S
   // would expose the second entry, which is not visible, so no prediction.
   always_comb begin
      req_if.pred_valid  = 1'b0;
      req_if.pred_target = ras_top_data;
      if (w_s_push) begin
         req_if.pred_target = r_s_addr;
      end
      if (w_accept && w_req_is_ret) begin
         if (w_s_push) begin
            req_if.pred_valid = 1'b1;
         end else if (r_s_valid) begin
            req_if.pred_valid = 1'b0;
         end else begin
            req_if.pred_valid = ras_top_valid && w_depth_nz;
         end
      end
   end

   assign req_if.req_ready = w_ready;

   // ---------------------------------------------------------------- stats
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (commit_ret_valid) begin
         if (commit_ret_hit) begin
            if (r_hit_cnt != '1) begin
               r_hit_cnt <= r_hit_cnt + 1'b1;
            end
         end else begin
            if (r_miss_cnt != '1) begin
               r_miss_cnt <= r_miss_cnt + 1'b1;
            end
         end
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_ras_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ras_ctrl
// Bench for ras_ctrl. A small RAS model closes the loop on ras_top_*.
// Per-cycle vectors carry expected handshake/prediction values; the RAS
// command each vector should cause is queued and compared one cycle later.
// ----------------------------------------------------------------------------
module tb_ras_ctrl;
   localparam int ENTRIES_NUM = 8;
   localparam int CNT_W       = 16;

   localparam logic [1:0] K_N  = 2'd0;
   localparam logic [1:0] K_C  = 2'd1;
   localparam logic [1:0] K_R  = 2'd2;
   localparam logic [1:0] K_CR = 2'd3;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush_in;
   logic             ras_push_req;
   logic             ras_pop_req;
   logic [31:0]      ras_push_data;
   logic             ras_flush;
   logic             ras_top_valid;
   logic [31:0]      ras_top_data;
   logic             commit_ret_valid;
   logic             commit_ret_hit;
   logic [CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0] miss_cnt;

   int checks   = 0;
   int failures = 0;

   ras_ctrl_if bus ();

   ras_ctrl #(
      .ENTRIES_NUM (ENTRIES_NUM),
      .CNT_W       (CNT_W)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .flush_in         (flush_in),
      .req_if           (bus),
      .ras_push_req     (ras_push_req),
      .ras_pop_req      (ras_pop_req),
      .ras_push_data    (ras_push_data),
      .ras_flush        (ras_flush),
      .ras_top_valid    (ras_top_valid),
      .ras_top_data     (ras_top_data),
      .commit_ret_valid (commit_ret_valid),
      .commit_ret_hit   (commit_ret_hit),
      .hit_cnt          (hit_cnt),
      .miss_cnt         (miss_cnt)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- RAS model
   // Plain LIFO that drops its oldest entry when full; a push caused by a
   // CALL_RET replaces the top (the bench remembers what it got accepted).
   logic [31:0] m_q[$];
   logic        m_s_cr;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q.delete();
         m_s_cr        <= 1'b0;
         ras_top_valid <= 1'b0;
         ras_top_data  <= 32'h0;
      end else begin
         m_s_cr <= bus.req_valid && bus.req_ready && (bus.req_kind == K_CR);
         if (ras_flush) begin
            m_q.delete();
         end else if (ras_push_req) begin
            if (m_s_cr && (m_q.size() > 0)) begin
               void'(m_q.pop_back());
            end else if (m_q.size() == ENTRIES_NUM) begin
               void'(m_q.pop_front());
            end
            m_q.push_back(ras_push_data);
         end else if (ras_pop_req && (m_q.size() > 0)) begin
            void'(m_q.pop_back());
         end
         ras_top_valid <= (m_q.size() != 0);
         ras_top_data  <= (m_q.size() != 0) ? m_q[$] : 32'h0;
      end
   end

   // ---------------------------------------------------------------- checking
   typedef struct {
      logic        v;
      logic [1:0]  k;
      logic [31:0] pc;
      logic        fl;
      logic        e_ready;
      logic        e_pv;
      logic [31:0] e_pt;
      logic        e_push;
      logic        e_pop;
      logic        e_rflush;
      logic [31:0] e_pdata;
   } vec_t;

   typedef struct {
      string       tag;
      logic        push;
      logic        pop;
      logic        rflush;
      logic [31:0] data;
   } op_t;

   op_t  exp_q[$];
   vec_t tbl[$];

   function automatic vec_t mk(input logic v, input logic [1:0] k, input logic [31:0] pc,
                               input logic fl, input logic er, input logic epv,
                               input logic [31:0] ept, input logic epu, input logic epo,
                               input logic erf, input logic [31:0] ed);
      vec_t r;
      r.v = v; r.k = k; r.pc = pc; r.fl = fl;
      r.e_ready = er; r.e_pv = epv; r.e_pt = ept;
      r.e_push = epu; r.e_pop = epo; r.e_rflush = erf; r.e_pdata = ed;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   // Compare the RAS command now on the outputs with the oldest expectation
   task automatic check_ops();
      op_t o;
      if (exp_q.size() != 0) begin
         o = exp_q.pop_front();
         chk({o.tag, " push_req"}, 32'(ras_push_req), 32'(o.push));
         chk({o.tag, " pop_req"},  32'(ras_pop_req),  32'(o.pop));
         chk({o.tag, " ras_flush"}, 32'(ras_flush),   32'(o.rflush));
         if (o.push) begin
            chk({o.tag, " push_data"}, ras_push_data, o.data);
         end
      end
   endtask

   task automatic apply(input string tag, input vec_t x);
      op_t o;
      @(negedge clk);
      check_ops();
      bus.req_valid = x.v;
      bus.req_kind  = x.k;
      bus.req_pc    = x.pc;
      flush_in      = x.fl;
      #1;
      $display("txn %s v=%0d kind=%0d pc=0x%08h flush=%0d ready=%0d pv=%0d pt=0x%08h",
               tag, x.v, x.k, x.pc, x.fl, bus.req_ready, bus.pred_valid, bus.pred_target);
      chk({tag, " req_ready"},  32'(bus.req_ready),  32'(x.e_ready));
      chk({tag, " pred_valid"}, 32'(bus.pred_valid), 32'(x.e_pv));
      if (x.e_pv) begin
         chk({tag, " pred_target"}, bus.pred_target, x.e_pt);
      end
      o.tag = tag; o.push = x.e_push; o.pop = x.e_pop; o.rflush = x.e_rflush; o.data = x.e_pdata;
      exp_q.push_back(o);
   endtask

   task automatic idle(input string tag);
      apply(tag, mk(1'b0, K_N, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, " req_ready"},     32'(bus.req_ready),  32'd1);
      chk({tag, " pred_valid"},    32'(bus.pred_valid), 32'd0);
      chk({tag, " push_req"},      32'(ras_push_req),   32'd0);
      chk({tag, " pop_req"},       32'(ras_pop_req),    32'd0);
      chk({tag, " ras_flush"},     32'(ras_flush),      32'd0);
      chk({tag, " push_data"},     ras_push_data,       32'h0);
      chk({tag, " hit_cnt"},       32'(hit_cnt),        32'h0);
      chk({tag, " miss_cnt"},      32'(miss_cnt),       32'h0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset            = 1'b1;
      flush_in         = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_kind     = K_N;
      bus.req_pc       = 32'h0;
      commit_ret_valid = 1'b0;
      commit_ret_hit   = 1'b0;

      // ---- reset state (a RET is offered so pred_valid is meaningful)
      repeat (2) @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_kind  = K_R;
      #1;
      check_reset_values("reset");
      $display("txn reset-state ready=%0d pv=%0d", bus.req_ready, bus.pred_valid);
      @(negedge clk);
      bus.req_valid = 1'b0;
      reset         = 1'b0;

      // ---- main table: v kind pc flush | ready pv target | push pop rflush data
      tbl.push_back(mk(1, K_C,  32'h8000_0100, 0, 1, 0, 32'h0,         1, 0, 0, 32'h8000_0108));
      tbl.push_back(mk(1, K_R,  32'h8000_0200, 0, 1, 1, 32'h8000_0108, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, K_N,  32'h0,         0, 1, 0, 32'h0,         0, 0, 0, 32'h0));
      tbl.push_back(mk(1, K_R,  32'h0000_0300, 0, 1, 0, 32'h0,         0, 0, 0, 32'h0));
      tbl.push_back(mk(1, K_C,  32'h0000_1000, 0, 1, 0, 32'h0,         1, 0, 0, 32'h0000_1008));
      tbl.push_back(mk(1, K_C,  32'h0000_2000, 0, 1, 0, 32'h0,         1, 0, 0, 32'h0000_2008));
      tbl.push_back(mk(0, K_N,  32'h0,         0, 1, 0, 32'h0,         0, 0, 0, 32'h0));
      tbl.push_back(mk(1, K_CR, 32'h0000_3000, 0, 1, 1, 32'h0000_2008, 1, 0, 0, 32'h0000_3008));
      tbl.push_back(mk(1, K_R,  32'h0000_0400, 0, 1, 1, 32'h0000_3008, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, K_N,  32'h0,         0, 1, 0, 32'h0,         0, 0, 0, 32'h0));
      tbl.push_back(mk(1, K_R,  32'h0000_0410, 0, 1, 1, 32'h0000_1008, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, K_N,  32'h0,         0, 1, 0, 32'h0,         0, 0, 0, 32'h0));
      tbl.push_back(mk(1, K_CR, 32'h0000_5000, 0, 1, 0, 32'h0,         1, 0, 0, 32'h0000_5008));
      tbl.push_back(mk(0, K_N,  32'h0,         0, 1, 0, 32'h0,         0, 0, 0, 32'h0));
      tbl.push_back(mk(1, K_R,  32'h0000_0600, 0, 1, 1, 32'h0000_5008, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, K_N,  32'h0000_0700, 0, 1, 0, 32'h0,         0, 0, 0, 32'h0));
      tbl.push_back(mk(1, K_R,  32'h0000_0710, 0, 1, 0, 32'h0,         0, 0, 0, 32'h0));
      tbl.push_back(mk(0, K_R,  32'h0000_0720, 0, 1, 0, 32'h0,         0, 0, 0, 32'h0));
      tbl.push_back(mk(1, K_C,  32'h0000_A000, 0, 1, 0, 32'h0,         1, 0, 0, 32'h0000_A008));
      tbl.push_back(mk(1, K_C,  32'h0000_B000, 0, 1, 0, 32'h0,         1, 0, 0, 32'h0000_B008));
      tbl.push_back(mk(0, K_N,  32'h0,         0, 1, 0, 32'h0,         0, 0, 0, 32'h0));
      tbl.push_back(mk(1, K_R,  32'h0000_0800, 0, 1, 1, 32'h0000_B008, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, K_R,  32'h0000_0810, 0, 1, 0, 32'h0,         0, 1, 0, 32'h0));
      tbl.push_back(mk(1, K_C,  32'h0000_C000, 0, 1, 0, 32'h0,         1, 0, 0, 32'h0000_C008));
      tbl.push_back(mk(1, K_C,  32'h0000_D000, 0, 1, 0, 32'h0,         1, 0, 0, 32'h0000_D008));
      tbl.push_back(mk(0, K_N,  32'h0,         0, 1, 0, 32'h0,         0, 0, 0, 32'h0));
      tbl.push_back(mk(1, K_R,  32'h0000_0820, 0, 1, 1, 32'h0000_D008, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, K_N,  32'h0,         0, 1, 0, 32'h0,         0, 0, 0, 32'h0));
      tbl.push_back(mk(1, K_R,  32'h0000_0830, 0, 1, 1, 32'h0000_C008, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, K_N,  32'h0,         0, 1, 0, 32'h0,         0, 0, 0, 32'h0));

      foreach (tbl[i]) begin
         apply($sformatf("tbl%0d", i), tbl[i]);
      end
      idle("tbl-drain");

      // ---- saturation: nine CALLs, then nine spaced RETs in LIFO order
      for (int k = 1; k <= 9; k++) begin
         apply($sformatf("sat-call%0d", k),
               mk(1, K_C, 32'(k * 256), 0, 1, 0, 32'h0, 1, 0, 0, 32'(k * 256 + 8)));
      end
      idle("sat-gap");
      for (int j = 0; j < 9; j++) begin
         if (j < 8) begin
            apply($sformatf("sat-ret%0d", j),
                  mk(1, K_R, 32'h0F00 + 32'(j), 0, 1, 1, 32'((9 - j) * 256 + 8), 0, 1, 0, 32'h0));
         end else begin
            apply($sformatf("sat-ret%0d", j),
                  mk(1, K_R, 32'h0F00 + 32'(j), 0, 1, 0, 32'h0, 0, 0, 0, 32'h0));
         end
         idle($sformatf("sat-idle%0d", j));
      end

      // ---- flush colliding with a CALL, then a double flush
      apply("fl-call0", mk(1, K_C, 32'h4000, 0, 1, 0, 32'h0, 1, 0, 0, 32'h4008));
      apply("fl-call1", mk(1, K_C, 32'h4100, 0, 1, 0, 32'h0, 1, 0, 0, 32'h4108));
      idle("fl-idle0");
      idle("fl-idle1");
      apply("fl-n",    mk(1, K_C, 32'h4200, 1, 0, 0, 32'h0, 0, 0, 1, 32'h0));
      apply("fl-n1",   mk(1, K_C, 32'h4300, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
      apply("fl-n2",   mk(1, K_R, 32'h4400, 0, 1, 0, 32'h0, 0, 0, 0, 32'h0));
      idle("fl-idle2");
      apply("fl2-a",   mk(0, K_N, 32'h0, 1, 0, 0, 32'h0, 0, 0, 1, 32'h0));
      apply("fl2-b",   mk(0, K_N, 32'h0, 1, 0, 0, 32'h0, 0, 0, 1, 32'h0));
      apply("fl2-c",   mk(0, K_N, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
      apply("fl2-d",   mk(1, K_C, 32'h4500, 0, 1, 0, 32'h0, 1, 0, 0, 32'h4508));
      idle("fl2-drain");
      @(negedge clk);
      check_ops();
      bus.req_valid = 1'b0;
      flush_in      = 1'b0;

      // ---- statistics: saturate hits, count misses, survive a flush
      for (int i = 0; i < 70000; i++) begin
         @(negedge clk);
         if (i == 2) begin
            chk("stat-hit2", 32'(hit_cnt), 32'd2);
         end
         commit_ret_valid = 1'b1;
         commit_ret_hit   = 1'b1;
      end
      @(negedge clk);
      commit_ret_valid = 1'b0;
      chk("stat-hit-sat", 32'(hit_cnt), 32'hFFFF);
      chk("stat-miss0",   32'(miss_cnt), 32'd0);
      $display("txn stats-70000-hits hit=0x%04h miss=0x%04h", hit_cnt, miss_cnt);
      for (int i = 0; i < 3; i++) begin
         commit_ret_valid = 1'b1;
         commit_ret_hit   = 1'b0;
         @(negedge clk);
      end
      commit_ret_valid = 1'b0;
      chk("stat-miss3", 32'(miss_cnt), 32'd3);
      commit_ret_valid = 1'b1;
      commit_ret_hit   = 1'b0;
      #1;
      chk("stat-latency", 32'(miss_cnt), 32'd3);
      @(negedge clk);
      commit_ret_valid = 1'b0;
      chk("stat-miss4", 32'(miss_cnt), 32'd4);
      flush_in = 1'b1;
      @(negedge clk);
      flush_in = 1'b0;
      @(negedge clk);
      chk("stat-flush-hit",  32'(hit_cnt),  32'hFFFF);
      chk("stat-flush-miss", 32'(miss_cnt), 32'd4);
      $display("txn stats-after-flush hit=0x%04h miss=0x%04h", hit_cnt, miss_cnt);

      // ---- asynchronous reset with a push in flight
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_kind  = K_C;
      bus.req_pc    = 32'h9000;
      @(negedge clk);
      bus.req_kind  = K_R;
      bus.req_pc    = 32'h9100;
      #1;
      chk("arst-pre-push", 32'(ras_push_req), 32'd1);
      chk("arst-pre-pv",   32'(bus.pred_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("arst");
      $display("txn async-reset ready=%0d pv=%0d push=%0d hit=0x%04h",
               bus.req_ready, bus.pred_valid, ras_push_req, hit_cnt);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
